onehot_event_encoder: RTL and testbench

- Inverse of the team's one-hot decoder. Samples a 2**N-bit one-hot request vector (buttons, display/row select lines) and synchronizes and debounces it.
- Priority-encodes each new press into an N-bit code. Delivers exactly one code per press over a valid/ready handshake to downstream control logic.
- Code mapping matches the decoder: code k corresponds to vector bit (2**N-1-k), so code 0 is the MSB.

---
 rtl/onehot_event_encoder.sv | 102 ++++++++++
 tb/tb_onehot_event_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_event_encoder.sv
// Synchronizes and debounces a one-hot request vector, priority-encodes each new
// press (MSB = code 0) and delivers exactly one code per press over valid/ready.
module onehot_event_encoder #(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [(2**N)-1:0]   in,
    output logic [N-1:0]        code_out,
    output logic                multi,
    output logic                valid,
    input  logic                ready
);

    localparam int unsigned W  = 2 ** N;
    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESENT      = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  last;
    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic          stable;
    logic [N-1:0]  enc_code;
    logic          enc_multi;
    logic [N:0]    pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            last  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            if (sync2 != last) begin
                last <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stable = (sync2 == last) && (cnt == CNT_MAX);

    // Ascending scan so the highest set bit is assigned last and wins.
    always_comb begin
        enc_code = '0;
        pop      = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (last[i]) begin
                enc_code = N'(W - 1 - i);
            end
            pop = pop + (N + 1)'(last[i]);
        end
        enc_multi = (pop > (N + 1)'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= 1'b0;
            code_out <= '0;
            multi    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stable && (last != '0)) begin
                        code_out <= enc_code;
                        multi    <= enc_multi;
                        valid    <= 1'b1;
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        state <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (stable && (last == '0)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_event_encoder.sv
// Directed bench for onehot_event_encoder (N=2, STABLE_CYCLES=4) with
// hand-computed expectations for latency, codes, handshake, glitch and reset.
module tb_onehot_event_encoder;

    logic       clk;
    logic       reset;
    logic [3:0] in;
    logic [1:0] code_out;
    logic       multi;
    logic       valid;
    logic       ready;

    int n_cmp;
    int n_err;

    int vcount;
    int vfirst;
    int vcode;
    int vmulti;

    onehot_event_encoder #(.N(2), .STABLE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .code_out (code_out),
        .multi    (multi),
        .valid    (valid),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps n edges; records valid-high count, first valid edge (1-based) and its payload.
    task automatic run(input int n);
        vcount = 0;
        vfirst = 0;
        vcode  = -1;
        vmulti = -1;
        for (int e = 1; e <= n; e++) begin
            step();
            if (valid) begin
                if (vcount == 0) begin
                    vfirst = e;
                    vcode  = int'(code_out);
                    vmulti = int'(multi);
                end
                vcount++;
            end
        end
    endtask

    int tmp;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        in    = 4'b0000;
        ready = 1'b1;
        step();
        step();
        check_eq("reset_valid", int'(valid), 0);
        check_eq("reset_code", int'(code_out), 0);
        check_eq("reset_multi", int'(multi), 0);
        reset = 1'b0;

        // single press, ready high
        in = 4'b0100;
        run(30);
        check_eq("t1_first_edge", vfirst, 7);
        check_eq("t1_count", vcount, 1);
        check_eq("t1_code", vcode, 1);
        check_eq("t1_multi", vmulti, 0);
        in = 4'b0000;
        run(10);
        check_eq("t1_release_quiet", vcount, 0);

        // multi-bit vector, MSB wins
        in = 4'b1010;
        run(20);
        check_eq("t2_count", vcount, 1);
        check_eq("t2_first_edge", vfirst, 7);
        check_eq("t2_code", vcode, 0);
        check_eq("t2_multi", vmulti, 1);
        in = 4'b0000;
        run(10);

        // backpressure holds the event through release
        ready = 1'b0;
        in = 4'b0001;
        run(10);
        check_eq("t3_first_edge", vfirst, 7);
        check_eq("t3_count_pressed", vcount, 4);
        check_eq("t3_code", vcode, 3);
        in = 4'b0000;
        run(20);
        check_eq("t3_held_count", vcount, 20);
        check_eq("t3_held_code", int'(code_out), 3);
        check_eq("t3_held_multi", int'(multi), 0);
        ready = 1'b1;
        step();
        check_eq("t3_transfer_drop", int'(valid), 0);
        run(10);
        check_eq("t3_after_quiet", vcount, 0);
        in = 4'b0010;
        run(20);
        check_eq("t3_second_count", vcount, 1);
        check_eq("t3_second_code", vcode, 2);
        in = 4'b0000;
        run(10);

        // short glitch produces nothing
        in = 4'b0001;
        run(3);
        tmp = vcount;
        in = 4'b0000;
        run(10);
        check_eq("t4_glitch_count", tmp + vcount, 0);

        // bounce restarts the count, then a single event
        tmp = 0;
        for (int p = 0; p < 6; p++) begin
            in = (p % 2 == 0) ? 4'b0100 : 4'b0000;
            run(2);
            tmp += vcount;
        end
        check_eq("t4_bounce_quiet", tmp, 0);
        in = 4'b0100;
        run(20);
        check_eq("t4_hold_count", vcount, 1);
        check_eq("t4_hold_code", vcode, 1);
        in = 4'b0000;
        run(10);

        // reset mid-handshake with request held
        ready = 1'b0;
        in = 4'b0010;
        run(10);
        check_eq("t5_pending", int'(valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t5_reset_valid", int'(valid), 0);
        check_eq("t5_reset_code", int'(code_out), 0);
        check_eq("t5_reset_multi", int'(multi), 0);
        run(7);
        check_eq("t5_first_edge", vfirst, 7);
        check_eq("t5_code", vcode, 2);
        ready = 1'b1;
        step();
        check_eq("t5_transfer_drop", int'(valid), 0);
        in = 4'b0000;
        run(10);

        // change without release gives no event
        in = 4'b1000;
        run(15);
        check_eq("t6_first_count", vcount, 1);
        check_eq("t6_first_code", vcode, 0);
        in = 4'b0001;
        run(20);
        check_eq("t6_change_quiet", vcount, 0);
        in = 4'b0000;
        run(10);
        check_eq("t6_release_quiet", vcount, 0);
        in = 4'b0001;
        run(20);
        check_eq("t6_repress_count", vcount, 1);
        check_eq("t6_repress_code", vcode, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
